writeback_stage: RTL and testbench

- Final pipeline stage. Registers memory-stage results, selects the write-back value, and drives rd_writeback / rdval_writeback into the register file and the decode stage.
- Merges late results from the multi-cycle mult/div unit through a one-entry pending buffer with a ready/accept handshake.
- Produces exception status writes to the status register.

---
 rtl/writeback_stage_pkg.sv | 17 +
 rtl/writeback_stage_if.sv | 42 ++++
 rtl/writeback_stage_pending_buf.sv | 42 ++++
 rtl/writeback_stage.sv | 111 +++++++++++
 tb/tb_writeback_stage.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared constants and encodings for the write-back stage.
// Register index, data width, select codes and status target.
package writeback_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [REG_W-1:0] STATUS_REG = 5'd30;

  typedef enum logic [1:0] {
    WB_SEL_ALU  = 2'b00,
    WB_SEL_MEM  = 2'b01,
    WB_SEL_PC   = 2'b10,
    WB_SEL_NONE = 2'b11
  } wb_sel_e;

endpackage

// File: rtl/writeback_stage_if.sv
// M-stage, mult/div and register-file signals of the write-back stage.
// The master side drives the stage inputs; the slave side is the stage.
interface writeback_stage_if;
  import writeback_stage_pkg::*;

  logic              enable;
  logic              m_valid;
  logic [REG_W-1:0]  m_rd;
  logic [1:0]        m_wb_sel;
  logic [DATA_W-1:0] m_alu_result;
  logic [DATA_W-1:0] m_mem_data;
  logic [DATA_W-1:0] m_pc;
  logic              m_exc;
  logic [DATA_W-1:0] m_exc_code;
  logic              md_ready;
  logic [REG_W-1:0]  md_rd;
  logic [DATA_W-1:0] md_result;
  logic              md_accept;
  logic [REG_W-1:0]  rd_writeback;
  logic [DATA_W-1:0] rdval_writeback;
  logic              wb_valid;
  logic              pend_valid;

  modport master (
    output enable, m_valid, m_rd, m_wb_sel,
    output m_alu_result, m_mem_data, m_pc,
    output m_exc, m_exc_code,
    output md_ready, md_rd, md_result,
    input  md_accept, rd_writeback,
    input  rdval_writeback, wb_valid, pend_valid
  );

  modport slave (
    input  enable, m_valid, m_rd, m_wb_sel,
    input  m_alu_result, m_mem_data, m_pc,
    input  m_exc, m_exc_code,
    input  md_ready, md_rd, md_result,
    output md_accept, rd_writeback,
    output rdval_writeback, wb_valid, pend_valid
  );

endinterface

// File: rtl/writeback_stage_pending_buf.sv
// One-entry holding slot for mult/div results that lost arbitration.
// A newer pipe write to the same register supersedes the held value.
module wb_pending_buf
  import writeback_stage_pkg::*;
(
  input  logic              clk,
  input  logic              clr,
  input  logic              sup_en,
  input  logic [REG_W-1:0]  sup_rd,
  input  logic              md_en,
  input  logic [REG_W-1:0]  md_rd,
  input  logic [DATA_W-1:0] md_val,
  input  logic              take,
  output logic              valid,
  output logic [REG_W-1:0]  rd,
  output logic [DATA_W-1:0] val
);

  logic sup_hit;
  logic load;

  assign sup_hit = sup_en & valid & (sup_rd == rd);
  assign load    = md_en & sup_en & (sup_rd != md_rd);

  // Hold, drop or capture the single pending mult/div result.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      valid <= 1'b0;
      rd    <= '0;
      val   <= '0;
    end else if (take | sup_hit) begin
      valid <= 1'b0;
      rd    <= '0;
      val   <= '0;
    end else if (load) begin
      valid <= 1'b1;
      rd    <= md_rd;
      val   <= md_val;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: picks the register write for this cycle from
// the M stage, a held mult/div result or a fresh mult/div result.
module writeback_stage
  import writeback_stage_pkg::*;
(
  input logic                clk,
  input logic                clr,
  writeback_stage_if.slave   bus
);

  logic [DATA_W-1:0] sel_val;
  logic [REG_W-1:0]  pipe_rd;
  logic [DATA_W-1:0] pipe_val;
  logic              pipe_en;
  logic              md_en;
  logic              take;
  logic              pend_valid;
  logic [REG_W-1:0]  pend_rd;
  logic [DATA_W-1:0] pend_val;
  logic [REG_W-1:0]  nxt_rd;
  logic [DATA_W-1:0] nxt_val;
  logic [REG_W-1:0]  rd_q;
  logic [DATA_W-1:0] val_q;
  logic              wbv_q;

  // Decode the M-stage write value from the select code.
  always_comb begin
    sel_val = '0;
    unique case (bus.m_wb_sel)
      WB_SEL_ALU:  sel_val = bus.m_alu_result;
      WB_SEL_MEM:  sel_val = bus.m_mem_data;
      WB_SEL_PC:   sel_val = bus.m_pc + DATA_W'(1);
      WB_SEL_NONE: sel_val = '0;
    endcase
  end

  // Exceptions redirect the write to the status register.
  always_comb begin
    pipe_rd  = bus.m_rd;
    pipe_val = sel_val;
    if (bus.m_exc) begin
      pipe_rd  = STATUS_REG;
      pipe_val = bus.m_exc_code;
    end else if (bus.m_wb_sel == WB_SEL_NONE) begin
      pipe_rd  = '0;
      pipe_val = '0;
    end
  end

  assign pipe_en = bus.enable & bus.m_valid & (|pipe_rd);
  assign md_en   = bus.md_ready & ~pend_valid & (|bus.md_rd);
  assign take    = ~pipe_en & pend_valid;

  wb_pending_buf u_pend (
    .clk    (clk),
    .clr    (clr),
    .sup_en (pipe_en),
    .sup_rd (pipe_rd),
    .md_en  (md_en),
    .md_rd  (bus.md_rd),
    .md_val (bus.md_result),
    .take   (take),
    .valid  (pend_valid),
    .rd     (pend_rd),
    .val    (pend_val)
  );

  // Arbitrate: pipe first, then held entry, then fresh mult/div.
  always_comb begin
    nxt_rd  = '0;
    nxt_val = '0;
    unique case (1'b1)
      pipe_en: begin
        nxt_rd  = pipe_rd;
        nxt_val = pipe_val;
      end
      take: begin
        nxt_rd  = pend_rd;
        nxt_val = pend_val;
      end
      (~pipe_en & ~pend_valid & md_en): begin
        nxt_rd  = bus.md_rd;
        nxt_val = bus.md_result;
      end
      default: begin
        nxt_rd  = '0;
        nxt_val = '0;
      end
    endcase
  end

  // Register the selected write for the register file.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      rd_q  <= '0;
      val_q <= '0;
      wbv_q <= 1'b0;
    end else begin
      rd_q  <= nxt_rd;
      val_q <= nxt_val;
      wbv_q <= |nxt_rd;
    end
  end

  assign bus.rd_writeback    = rd_q;
  assign bus.rdval_writeback = val_q;
  assign bus.wb_valid        = wbv_q;
  assign bus.pend_valid      = pend_valid;
  assign bus.md_accept       = ~pend_valid;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed plus random bench for writeback_stage against a
// queue-based model of the write-back arbitration rules.
module tb_writeback_stage;
  import writeback_stage_pkg::*;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  writeback_stage_if bus ();

  writeback_stage dut (
    .clk (clk),
    .clr (clr),
    .bus (bus.slave)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] val;
  } ent_t;

  ent_t        pq[$];
  logic [4:0]  e_rd;
  logic [31:0] e_val;
  int          nchk = 0;
  int          npass = 0;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    nchk++;
    assert (o === e) begin
      npass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic chk_all(string tag);
    chk({tag, "_rd"}, 32'(bus.rd_writeback), 32'(e_rd));
    chk({tag, "_val"}, bus.rdval_writeback, e_val);
    chk({tag, "_wbv"}, 32'(bus.wb_valid), 32'(e_rd != 0));
    chk({tag, "_pend"}, 32'(bus.pend_valid), 32'(pq.size() != 0));
    chk({tag, "_acc"}, 32'(bus.md_accept), 32'(pq.size() == 0));
  endtask

  task automatic model();
    logic [4:0]  prd;
    logic [31:0] pval;
    logic        pc;
    logic        mc;
    ent_t        m;
    prd  = 0;
    pval = 0;
    if (bus.m_exc) begin
      prd  = 30;
      pval = bus.m_exc_code;
    end else begin
      case (bus.m_wb_sel)
        2'd0: begin prd = bus.m_rd; pval = bus.m_alu_result; end
        2'd1: begin prd = bus.m_rd; pval = bus.m_mem_data; end
        2'd2: begin prd = bus.m_rd; pval = bus.m_pc + 1; end
        default: prd = 0;
      endcase
    end
    pc = bus.enable && bus.m_valid && prd != 0;
    mc = bus.md_ready && pq.size() == 0 && bus.md_rd != 0;
    if (pc) begin
      e_rd  = prd;
      e_val = pval;
      if (pq.size() != 0 && pq[0].rd == prd) pq.delete();
      if (mc && bus.md_rd != prd) begin
        m.rd  = bus.md_rd;
        m.val = bus.md_result;
        pq.push_back(m);
      end
    end else if (pq.size() != 0) begin
      m     = pq.pop_front();
      e_rd  = m.rd;
      e_val = m.val;
    end else if (mc) begin
      e_rd  = bus.md_rd;
      e_val = bus.md_result;
    end else begin
      e_rd  = 0;
      e_val = 0;
    end
  endtask

  task automatic step(string tag);
    model();
    @(posedge clk);
    #1;
    chk_all(tag);
  endtask

  task automatic idle();
    bus.enable       = 1'b1;
    bus.m_valid      = 1'b0;
    bus.m_rd         = '0;
    bus.m_wb_sel     = 2'd0;
    bus.m_alu_result = '0;
    bus.m_mem_data   = '0;
    bus.m_pc         = '0;
    bus.m_exc        = 1'b0;
    bus.m_exc_code   = '0;
    bus.md_ready     = 1'b0;
    bus.md_rd        = '0;
    bus.md_result    = '0;
  endtask

  task automatic pipe(logic [4:0] rd, logic [1:0] sel, logic [31:0] v);
    bus.m_valid      = 1'b1;
    bus.m_rd         = rd;
    bus.m_wb_sel     = sel;
    bus.m_alu_result = v;
    bus.m_mem_data   = ~v;
    bus.m_pc         = v;
    bus.m_exc        = 1'b0;
  endtask

  task automatic md(logic r, logic [4:0] rd, logic [31:0] v);
    bus.md_ready  = r;
    bus.md_rd     = rd;
    bus.md_result = v;
  endtask

  initial begin
    clr = 1'b0;
    idle();
    e_rd  = 0;
    e_val = 0;
    #12;
    chk_all("reset");
    clr = 1'b1;

    pipe(5, 2'd0, 32'h1234);
    step("alu");
    chk("alu_rd5", 32'(bus.rd_writeback), 32'd5);
    chk("alu_v", bus.rdval_writeback, 32'h1234);

    pipe(31, 2'd2, 32'hFFFF_FFFF);
    step("pcwrap");
    chk("pcwrap_v", bus.rdval_writeback, 32'h0);

    pipe(3, 2'd0, 32'd7);
    md(1'b1, 8, 32'd99);
    step("pend_ld");
    chk("pend_ld_p", 32'(bus.pend_valid), 32'd1);
    idle();
    step("pend_drn");
    chk("pend_drn_v", bus.rdval_writeback, 32'd99);

    pipe(1, 2'd0, 32'd11);
    md(1'b1, 8, 32'd99);
    step("sup_ld");
    idle();
    pipe(8, 2'd0, 32'd1);
    step("sup");
    chk("sup_v", bus.rdval_writeback, 32'd1);
    idle();
    step("sup_idle");

    pipe(9, 2'd0, 32'd5);
    bus.m_exc      = 1'b1;
    bus.m_exc_code = 32'd4;
    step("exc");
    chk("exc_rd", 32'(bus.rd_writeback), 32'd30);
    pipe(0, 2'd0, 32'd55);
    step("rd0");

    pipe(2, 2'd1, 32'h0F0F_0000);
    md(1'b1, 4, 32'd44);
    step("stall_ld");
    md(1'b0, 0, 0);
    bus.enable = 1'b0;
    pipe(6, 2'd0, 32'd66);
    step("stall_drn");
    idle();
    md(1'b1, 0, 32'd77);
    step("md_r0");
    md(1'b1, 12, 32'd88);
    step("md_direct");

    idle();
    pipe(3, 2'd0, 32'd3);
    md(1'b1, 9, 32'd9);
    step("rst_ld");
    idle();
    #2;
    clr = 1'b0;
    #1;
    pq.delete();
    e_rd  = 0;
    e_val = 0;
    chk_all("rst_mid");
    @(negedge clk);
    clr = 1'b1;
    step("rst_rel");

    for (int i = 0; i < 400; i++) begin
      bus.enable       = ($urandom_range(0, 7) != 0);
      bus.m_valid      = $urandom_range(0, 1);
      bus.m_rd         = 5'($urandom_range(0, 7));
      bus.m_wb_sel     = 2'($urandom_range(0, 3));
      bus.m_alu_result = $urandom;
      bus.m_mem_data   = $urandom;
      bus.m_pc         = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus.m_exc        = ($urandom_range(0, 9) == 0);
      bus.m_exc_code   = $urandom;
      bus.md_ready     = $urandom_range(0, 1);
      bus.md_rd        = 5'($urandom_range(0, 7));
      bus.md_result    = $urandom;
      step("rand");
    end

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
